// File: rtl/uart_echo_fifo.sv
// UART echo top: received bytes are queued in a FIFO and re-sent by a small tx FSM.
// Define ECHO_CRLF_EN to send an LF after every echoed CR (0x0D).

`ifndef B9600
`define B9600 1250
`endif
`ifndef B19200
`define B19200 625
`endif
`ifndef B115200
`define B115200 104
`endif

module uart_rx #(
    parameter int BAUDRATE = `B9600
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       rx_i,
    output logic       rcv_o,
    output logic [7:0] data_o
);
    localparam int CNT_W = $clog2(BAUDRATE) + 1;
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(BAUDRATE - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(BAUDRATE / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [3:0]       bits_q, bits_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             rcv_q, rcv_d;
    logic [1:0]       sync_q;
    logic             rx_s;

    assign rx_s   = sync_q[1];
    assign rcv_o  = rcv_q;
    assign data_o = data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            rcv_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            baud_q  <= baud_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
        end
    end

    // Start bit is re-checked half a bit in, so every later sample lands mid-bit.
    always_comb begin
        state_d = state_q;
        baud_d  = (baud_q != '0) ? baud_q - CNT_W'(1) : '0;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    baud_d  = BIT_HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (baud_q == '0) begin
                    if (!rx_s) begin
                        baud_d  = BIT_FULL;
                        bits_d  = 4'd8;
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (baud_q == '0) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    baud_d  = BIT_FULL;
                    bits_d  = bits_q - 4'd1;
                    if (bits_q == 4'd1) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_q == '0) begin
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        rcv_d  = 1'b1;
                        data_d = shreg_q;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end
endmodule

module uart_tx #(
    parameter int BAUDRATE = `B9600
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o
);
    localparam int CNT_W = $clog2(BAUDRATE) + 1;
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(BAUDRATE - 1);

    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [3:0]       bits_q, bits_d;
    logic [CNT_W-1:0] baud_q, baud_d;

    assign tx_o    = tx_q;
    assign ready_o = ~busy_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            shreg_q <= '1;
            bits_q  <= '0;
            baud_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            baud_q  <= baud_d;
        end
    end

    // shreg holds {stop, data}; the start bit goes straight onto the line.
    always_comb begin
        busy_d  = busy_q;
        tx_d    = tx_q;
        shreg_d = shreg_q;
        bits_d  = bits_q;
        baud_d  = baud_q;
        if (!busy_q) begin
            tx_d = 1'b1;
            if (start_i) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shreg_d = {1'b1, data_i};
                bits_d  = 4'd9;
                baud_d  = BIT_FULL;
            end
        end else if (baud_q != '0) begin
            baud_d = baud_q - CNT_W'(1);
        end else if (bits_q == 4'd0) begin
            busy_d = 1'b0;
        end else begin
            tx_d    = shreg_q[0];
            shreg_d = {1'b1, shreg_q[8:1]};
            bits_d  = bits_q - 4'd1;
            baud_d  = BIT_FULL;
        end
    end
endmodule

module uart_echo_fifo #(
    parameter int BAUDRATE = `B9600,
    parameter int DEPTH    = 16,
    parameter int LED_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic                     tx,
    input  logic                     tx_en,
    output logic [LED_W-1:0]         leds,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

`ifdef ECHO_CRLF_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUSY, S_DRAIN, S_LF} state_t;
    logic crlf_q, crlf_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_DRAIN} state_t;
`endif

    state_t            state_q, state_d;
    logic              rstn;
    logic              rcv;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              push;
    logic              pop;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overrun_q, overrun_d;
    logic [LED_W-1:0]  leds_q, leds_d;

    assign rstn    = ~rst;
    assign leds    = leds_q;
    assign overrun = overrun_q;
    assign level   = level_q;

    uart_rx #(.BAUDRATE(BAUDRATE)) u_rx (
        .clk_i  (clk),
        .rstn_i (rstn),
        .rx_i   (rx),
        .rcv_o  (rcv),
        .data_o (rx_data)
    );

    uart_tx #(.BAUDRATE(BAUDRATE)) u_tx (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .start_i (tx_start),
        .data_i  (tx_data),
        .tx_o    (tx),
        .ready_o (tx_ready)
    );

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign pop  = (state_q == S_LOAD);
    assign push = rcv && ((level_q != FULL_LVL) || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        leds_d    = leds_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
        if (rcv) begin
            leds_d = rx_data[LED_W-1:0];
            if (!push) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            leds_q    <= '0;
`ifdef ECHO_CRLF_EN
            crlf_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            leds_q    <= leds_d;
`ifdef ECHO_CRLF_EN
            crlf_q    <= crlf_d;
`endif
        end
    end

    // tx_en only gates leaving IDLE, so a frame (or a pending LF) always completes.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        tx_data  = mem_q[rd_ptr_q];
`ifdef ECHO_CRLF_EN
        crlf_d   = crlf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_en && (level_q != '0) && tx_ready) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_start = 1'b1;
                state_d  = S_BUSY;
`ifdef ECHO_CRLF_EN
                crlf_d   = (mem_q[rd_ptr_q] == 8'h0D);
`endif
            end
            S_BUSY: begin
                if (!tx_ready) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tx_ready) begin
`ifdef ECHO_CRLF_EN
                    state_d = crlf_q ? S_LF : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef ECHO_CRLF_EN
            S_LF: begin
                tx_data  = 8'h0A;
                tx_start = 1'b1;
                crlf_d   = 1'b0;
                state_d  = S_BUSY;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end
endmodule
